// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N one-hot decoder.
// The optional error counter is enabled by defining DECODER_ERRCNT_EN.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_PULSE = 1;

  // Widest one-hot vector the helper can build; N_OUT must not exceed it.
  localparam int ONEHOT_MAX_W = 64;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int code, input int n);
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      v[i] = (i == code) && (i < n);
    end
    return v;
  endfunction

endpackage

// File: rtl/decoder_nto2n_seq_dwell_cnt.sv
// Loadable down-counter with a zero flag; times both the DRIVE and GAP phases.
// Decrement stops at zero so a stray decrement never wraps.
module decoder_dwell_cnt
  import decoder_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input, level or timed-pulse
// output and out-of-range detection. Define DECODER_ERRCNT_EN for the err_cnt port.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int N_OUT     = 4,
  parameter int MODE      = 0,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 0,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_code,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_onehot,
  output logic             out_valid,
  output logic             busy,
  output logic             err
`ifdef DECODER_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam bit PULSE_MODE = (MODE != MODE_LEVEL);
  localparam int MAX_LEN    = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  state_t           r_state;
  state_t           w_state_next;
  logic [N_OUT-1:0] r_onehot;
  logic [N_OUT-1:0] w_onehot_next;
  logic             r_valid;
  logic             r_err;
  logic             w_err_next;
  logic             w_accept;
  logic             w_in_range;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

  logic [ONEHOT_MAX_W-1:0] w_onehot_full;
  logic [N_OUT-1:0]        w_decoded;

  assign w_onehot_full = onehot(int'(in_code), N_OUT);

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_dec_bit
      assign w_decoded[gi] = w_onehot_full[gi];
    end
    if (N_OUT < ONEHOT_MAX_W) begin : g_hi_bits
      logic [ONEHOT_MAX_W-N_OUT-1:0] w_unused_hi;
      assign w_unused_hi = w_onehot_full[ONEHOT_MAX_W-1:N_OUT];
    end
  endgenerate

  // One extra bit so N_OUT == 2**SEL_W compares correctly.
  assign w_in_range = ({1'b0, in_code} < (SEL_W + 1)'(N_OUT));
  assign in_ready   = (r_state == IDLE);
  assign w_accept   = in_valid && in_ready && !clr;

  always_comb begin
    w_state_next   = r_state;
    w_onehot_next  = r_onehot;
    w_err_next     = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = PULSE_LOAD;
    w_cnt_dec      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_range) begin
            w_onehot_next = w_decoded;
            if (PULSE_MODE) begin
              w_state_next = DRIVE;
              w_cnt_load   = 1'b1;
            end
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (w_cnt_zero) begin
          w_onehot_next = '0;
          if (GAP_LEN > 0) begin
            w_state_next   = GAP;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = GAP_LOAD;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      GAP: begin
        w_onehot_next = '0;
        if (w_cnt_zero) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_onehot_next = '0;
      end
    endcase
  end

  decoder_dwell_cnt #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_load_val),
    .i_dec     (w_cnt_dec),
    .o_zero    (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else if (clr) begin
      r_state  <= IDLE;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_onehot <= w_onehot_next;
      r_valid  <= |w_onehot_next;
      r_err    <= w_err_next;
    end
  end

  assign out_onehot = r_onehot;
  assign out_valid  = r_valid;
  assign busy       = (r_state != IDLE);
  assign err        = r_err;

`ifdef DECODER_ERRCNT_EN
  logic [ERR_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= '0;
    end else if (w_err_next && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic [ERR_W-1:0] w_unused_err_w;
  assign w_unused_err_w = '0;
`endif

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench for decoder_nto2n_seq: two level-mode instances and one
// pulse-mode instance; err_cnt checks are compiled in with DECODER_ERRCNT_EN.
module tb_decoder_nto2n_seq;

  typedef struct {
    logic [3:0] oh;
    logic       busy;
    logic       rdy;
  } exp_c_t;

  logic clk;
  logic rst_n, rst_n_c;

  logic       a_clr, a_valid, a_rdy, a_ov, a_busy, a_err;
  logic [1:0] a_code;
  logic [3:0] a_oh;

  logic       b_clr, b_valid, b_rdy, b_ov, b_busy, b_err;
  logic [2:0] b_code;
  logic [4:0] b_oh;

  logic       c_clr, c_valid, c_rdy, c_ov, c_busy, c_err;
  logic [1:0] c_code;
  logic [3:0] c_oh;

`ifdef DECODER_ERRCNT_EN
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  logic [7:0] c_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] q_a[$];
  logic [4:0] q_b[$];
  exp_c_t     q_c[$];

  decoder_nto2n_seq #(.SEL_W(2), .N_OUT(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_valid), .in_code(a_code),
    .in_ready(a_rdy), .out_onehot(a_oh), .out_valid(a_ov), .busy(a_busy), .err(a_err)
`ifdef DECODER_ERRCNT_EN
    , .err_cnt(a_cnt)
`endif
  );

  decoder_nto2n_seq #(.SEL_W(3), .N_OUT(5), .MODE(0), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_valid), .in_code(b_code),
    .in_ready(b_rdy), .out_onehot(b_oh), .out_valid(b_ov), .busy(b_busy), .err(b_err)
`ifdef DECODER_ERRCNT_EN
    , .err_cnt(b_cnt)
`endif
  );

  decoder_nto2n_seq #(.SEL_W(2), .N_OUT(4), .MODE(1), .PULSE_LEN(3), .GAP_LEN(2)) u_c (
    .clk(clk), .rst_n(rst_n_c), .clr(c_clr), .in_valid(c_valid), .in_code(c_code),
    .in_ready(c_rdy), .out_onehot(c_oh), .out_valid(c_ov), .busy(c_busy), .err(c_err)
`ifdef DECODER_ERRCNT_EN
    , .err_cnt(c_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_c(input logic [3:0] oh, input logic bz, input logic rd);
    exp_c_t e;
    e.oh = oh; e.busy = bz; e.rdy = rd;
    q_c.push_back(e);
  endtask

  task automatic pop_check_c(input string tag);
    exp_c_t e;
    if (q_c.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q_c.pop_front();
      check({tag, "_oh"}, 32'(c_oh), 32'(e.oh));
      check({tag, "_ov"}, 32'(c_ov), 32'(e.oh != 4'd0));
      check({tag, "_busy"}, 32'(c_busy), 32'(e.busy));
      check({tag, "_rdy"}, 32'(c_rdy), 32'(e.rdy));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad[5];
    logic [3:0] ea;
    logic [4:0] eb;
    bad = '{6, 5, 7, 6, 5};
    rst_n = 1'b0; rst_n_c = 1'b0;
    a_clr = 0; a_valid = 0; a_code = 0;
    b_clr = 0; b_valid = 0; b_code = 0;
    c_clr = 0; c_valid = 0; c_code = 0;
    #2;
    check("rst_a_oh", 32'(a_oh), 32'd0);
    check("rst_a_ov", 32'(a_ov), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check("rst_a_rdy", 32'(a_rdy), 32'd1);
    check("rst_c_busy", 32'(c_busy), 32'd0);
    check("rst_c_rdy", 32'(c_rdy), 32'd1);
`ifdef DECODER_ERRCNT_EN
    check("rst_b_cnt", 32'(b_cnt), 32'd0);
`endif
    tick(); tick();
    rst_n = 1'b1; rst_n_c = 1'b1;

    // Level mode, codes 0..3 back to back
    for (int c = 0; c < 4; c++) begin
      a_valid = 1'b1; a_code = 2'(c);
      q_a.push_back(4'(1) << c);
      tick();
      ea = q_a.pop_front();
      check($sformatf("a_code%0d_oh", c), 32'(a_oh), 32'(ea));
      check($sformatf("a_code%0d_ov", c), 32'(a_ov), 32'd1);
      check($sformatf("a_code%0d_err", c), 32'(a_err), 32'd0);
    end
    a_valid = 1'b0; a_code = 2'd0;
    tick();
    check("a_hold_oh", 32'(a_oh), 32'b1000);
    check("a_busy", 32'(a_busy), 32'd0);

    // Level mode, N_OUT=5 with out-of-range codes and saturating count
    b_valid = 1'b1; b_code = 3'd2;
    q_b.push_back(5'b00100);
    tick();
    eb = q_b.pop_front();
    check("b_code2_oh", 32'(b_oh), 32'(eb));
    for (int i = 0; i < 5; i++) begin
      b_code = 3'(bad[i]);
      q_b.push_back(5'b00100);
      tick();
      eb = q_b.pop_front();
      check($sformatf("b_bad%0d_oh", i), 32'(b_oh), 32'(eb));
      check($sformatf("b_bad%0d_err", i), 32'(b_err), 32'd1);
`ifdef DECODER_ERRCNT_EN
      check($sformatf("b_bad%0d_cnt", i), 32'(b_cnt), 32'((i < 2) ? i + 1 : 3));
`endif
    end
    b_code = 3'd4;
    q_b.push_back(5'b10000);
    tick();
    eb = q_b.pop_front();
    check("b_code4_oh", 32'(b_oh), 32'(eb));
    check("b_code4_err", 32'(b_err), 32'd0);
    b_valid = 1'b0;
    tick();
    check("b_idle_err", 32'(b_err), 32'd0);
    check("b_idle_oh", 32'(b_oh), 32'b10000);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    check("b_clr_oh", 32'(b_oh), 32'd0);
`ifdef DECODER_ERRCNT_EN
    check("b_clr_cnt", 32'(b_cnt), 32'd0);
`endif

    // Pulse mode, valid held with code 1: two full periods of 6
    check("c_pre_rdy", 32'(c_rdy), 32'd1);
    c_valid = 1'b1; c_code = 2'd1;
    for (int j = 0; j < 12; j++) begin
      push_c((j % 6 < 3) ? 4'b0010 : 4'b0000, (j % 6) < 5, (j % 6) == 5);
    end
    for (int j = 0; j < 12; j++) begin
      tick();
      pop_check_c($sformatf("c_per%0d", j));
      if (j == 0) c_code = 2'd3;
      if (j == 3) c_code = 2'd1;
      if (j == 11) c_valid = 1'b0;
    end

    // clr during the second DRIVE cycle
    c_valid = 1'b1; c_code = 2'd2;
    push_c(4'b0100, 1'b1, 1'b0);
    push_c(4'b0100, 1'b1, 1'b0);
    push_c(4'b0000, 1'b0, 1'b1);
    push_c(4'b0000, 1'b0, 1'b1);
    tick();
    pop_check_c("c_clr_d1");
    c_valid = 1'b0;
    tick();
    pop_check_c("c_clr_d2");
    c_clr = 1'b1; c_valid = 1'b1; c_code = 2'd0;
    tick();
    pop_check_c("c_clr_after");
    tick();
    pop_check_c("c_clr_idle_valid");
    c_clr = 1'b0; c_valid = 1'b0;

    // Asynchronous reset mid-DRIVE, then normal accept
    c_valid = 1'b1; c_code = 2'd3;
    tick();
    c_valid = 1'b0;
    check("c_ar_d1_oh", 32'(c_oh), 32'b1000);
    tick();
    check("c_ar_d2_busy", 32'(c_busy), 32'd1);
    #2 rst_n_c = 1'b0;
    #1;
    check("c_ar_oh", 32'(c_oh), 32'd0);
    check("c_ar_ov", 32'(c_ov), 32'd0);
    check("c_ar_busy", 32'(c_busy), 32'd0);
    check("c_ar_rdy", 32'(c_rdy), 32'd1);
    @(negedge clk);
    rst_n_c = 1'b1;
    c_valid = 1'b1; c_code = 2'd0;
    push_c(4'b0001, 1'b1, 1'b0);
    push_c(4'b0001, 1'b1, 1'b0);
    push_c(4'b0001, 1'b1, 1'b0);
    push_c(4'b0000, 1'b1, 1'b0);
    tick();
    c_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      pop_check_c($sformatf("c_post%0d", j));
      if (j < 3) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
